// File: rtl/tri_fetch_pkg.sv
// tri_fetch_pkg
// Shared definitions for the triangle fetch stage: the sweep state
// encoding, the default record size in 32-bit words, and the bit offsets
// of each vertex coordinate inside a packed triangle record.
//
// Record layout (bit offsets, each field 32 bits wide):
//   vertex 0: x @ 0,   y @ 32,  z @ 64
//   vertex 1: x @ 96,  y @ 128, z @ 160
//   vertex 2: x @ 192, y @ 224, z @ 256
package tri_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  localparam int NDWORDS_TRI = 9;

  localparam int V0X_OFS = 0;
  localparam int V0Y_OFS = 32;
  localparam int V0Z_OFS = 64;
  localparam int V1X_OFS = 96;
  localparam int V1Y_OFS = 128;
  localparam int V1Z_OFS = 160;
  localparam int V2X_OFS = 192;
  localparam int V2Y_OFS = 224;
  localparam int V2Z_OFS = 256;

endpackage

// File: rtl/tri_fetch_sync.sv
// sync_fifo
// Single-clock FIFO with registered pointers and an occupancy counter.
// The head entry is presented combinationally on rdata whenever the FIFO
// is non-empty. A push is accepted on a full FIFO only if a pop happens in
// the same cycle, which frees the slot being written.
//
// Parameters:
//   WIDTH - entry width in bits
//   DEPTH - number of entries, a power of two and at least 2
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   push, wdata     - write request and data
//   pop             - remove head entry (ignored when empty)
//   rdata           - head entry
//   full, empty     - occupancy flags
//   count           - number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/tri_fetch.sv
// tri_fetch
// Sweeps triangle indices 0..ntris-1, requests each record from the
// element reader one at a time, and streams the returned records (with
// their index and a last flag) to the intersect stage through a small
// output FIFO. Requests stall while the FIFO is full, so a slow consumer
// throttles the reader instead of losing data.
//
// Parameters:
//   NDWORDS    - 32-bit words per triangle record (ELEMSZ = 32*NDWORDS)
//   FIFO_DEPTH - output buffer entries, power of two, at least 2
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   start, ntris                - begin a sweep of ntris triangles
//   busy, done                  - sweep active / one-cycle completion pulse
//   rd_read, rd_index           - request to the element reader
//   rd_iready, rd_ovalid, rd_data - reader response handshake and record
//   tri_valid, tri_ready        - downstream stream handshake
//   tri_data, tri_index, tri_last - downstream record, its index, last flag
module tri_fetch
  import tri_fetch_pkg::*;
#(
  parameter int NDWORDS    = NDWORDS_TRI,
  parameter int FIFO_DEPTH = 2,
  localparam int ELEMSZ    = 32 * NDWORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       ntris,
  output logic              busy,
  output logic              done,
  output logic              rd_read,
  output logic [31:0]       rd_index,
  input  logic              rd_iready,
  input  logic [ELEMSZ-1:0] rd_data,
  input  logic              rd_ovalid,
  output logic              tri_valid,
  input  logic              tri_ready,
  output logic [ELEMSZ-1:0] tri_data,
  output logic [31:0]       tri_index,
  output logic              tri_last
);

  // FIFO entry layout: {last, index, record}
  localparam int FW = ELEMSZ + 33;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [31:0]     idx;
  logic [31:0]     last_idx;
  logic            done_pulse;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [FW-1:0]   fifo_wdata;
  logic [FW-1:0]   fifo_rdata;

  logic            issue_ok;
  logic            capture;
  logic            cap_last;
  logic            sweep_end;

  // The full flag reflects the count before any pop this cycle, so a
  // pop never lets a new request slip in early.
  assign issue_ok  = (state == ISSUE) && !fifo_full;
  assign capture   = (state == WAIT) && rd_ovalid && rd_iready;
  assign cap_last  = (idx == last_idx);

  // The final entry is the only one left when it is popped in FLUSH.
  assign sweep_end = (state == FLUSH) && fifo_pop && (fifo_count == CW'(1));

  assign fifo_push  = capture;
  assign fifo_pop   = tri_valid && tri_ready;
  assign fifo_wdata = {cap_last, idx, rd_data};

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && (ntris != 32'd0)) state_next = ISSUE;
      ISSUE:   if (issue_ok) state_next = WAIT;
      WAIT:    if (capture) state_next = cap_last ? FLUSH : ISSUE;
      FLUSH:   if (sweep_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The index stops at ntris-1 by equality, so ntris = 2^32-1 never
  // needs the counter to wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= 32'd0;
      last_idx   <= 32'd0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if ((state == IDLE) && start) begin
        idx      <= 32'd0;
        last_idx <= ntris - 32'd1;
        if (ntris == 32'd0) done_pulse <= 1'b1;
      end
      if (capture && !cap_last) idx <= idx + 32'd1;
      if (sweep_end) done_pulse <= 1'b1;
    end
  end

  // Outputs are forced to zero while reset is held, and the stream
  // fields read as zero whenever no entry is presented.
  always_comb begin
    busy      = !reset && (state != IDLE);
    done      = !reset && done_pulse;
    rd_read   = !reset && (issue_ok || (state == WAIT));
    rd_index  = rd_read ? idx : 32'd0;
    tri_valid = !reset && !fifo_empty;
    tri_data  = tri_valid ? fifo_rdata[ELEMSZ-1:0] : '0;
    tri_index = tri_valid ? fifo_rdata[ELEMSZ +: 32] : 32'd0;
    tri_last  = tri_valid && fifo_rdata[FW-1];
  end

endmodule

// File: tb/tb_tri_fetch.sv
// tb_tri_fetch
// Self-checking bench for tri_fetch. A behavioural element reader answers
// each request after a configurable latency with a record derived from the
// requested index; the expected stream for a sweep of n triangles is simply
// indices 0..n-1 in order, each carrying that same derived record, with the
// last flag on n-1 and done one cycle after that final pop.
module tb_tri_fetch;
  import tri_fetch_pkg::*;

  localparam int ELEMSZ = 32 * NDWORDS_TRI;
  localparam int OFS [NDWORDS_TRI] = '{V0X_OFS, V0Y_OFS, V0Z_OFS,
                                       V1X_OFS, V1Y_OFS, V1Z_OFS,
                                       V2X_OFS, V2Y_OFS, V2Z_OFS};

  logic              clk;
  logic              reset;
  logic              start;
  logic [31:0]       ntris;
  logic              busy;
  logic              done;
  logic              rd_read;
  logic [31:0]       rd_index;
  logic              rd_iready;
  logic [ELEMSZ-1:0] rd_data;
  logic              rd_ovalid;
  logic              tri_valid;
  logic              tri_ready;
  logic [ELEMSZ-1:0] tri_data;
  logic [31:0]       tri_index;
  logic              tri_last;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rec_seed = 32'h1234_5678;
  int          rd_lat_max = 1;
  int          rd_stall_pct = 0;
  logic [31:0] slow_idx = 32'hFFFF_FFFF;
  int          slow_delay = 0;
  bit          stray_req = 0;
  int          handshakes = 0;
  int          slow_held = 0;
  int          last_latency = 0;

  tri_fetch #(
    .NDWORDS    (NDWORDS_TRI),
    .FIFO_DEPTH (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ntris     (ntris),
    .busy      (busy),
    .done      (done),
    .rd_read   (rd_read),
    .rd_index  (rd_index),
    .rd_iready (rd_iready),
    .rd_data   (rd_data),
    .rd_ovalid (rd_ovalid),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .tri_data  (tri_data),
    .tri_index (tri_index),
    .tri_last  (tri_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ELEMSZ-1:0] make_record(input logic [31:0] seed,
                                                    input logic [31:0] i);
    logic [ELEMSZ-1:0] r;
    r = '0;
    for (int w = 0; w < NDWORDS_TRI; w++)
      r[OFS[w] +: 32] = seed ^ (i * 32'h9E37_79B1) ^ (32'(w) << 24) ^ 32'(w * 7 + 1);
    return r;
  endfunction

  function automatic logic [ELEMSZ-1:0] junk_record();
    logic [ELEMSZ-1:0] r;
    r = '0;
    for (int w = 0; w < NDWORDS_TRI; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural element reader: one outstanding request, answered after
  // a latency of at least one cycle, optionally with an iready stall.
  initial begin : reader
    int          remaining;
    bit          pending;
    logic [31:0] req_idx;
    rd_ovalid = 1'b0;
    rd_iready = 1'b0;
    rd_data   = '0;
    pending   = 1'b0;
    remaining = 0;
    req_idx   = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        pending   = 1'b0;
        rd_ovalid = 1'b0;
        rd_iready = 1'b0;
      end else if (rd_ovalid && rd_iready) begin
        rd_ovalid = 1'b0;
        rd_iready = 1'b0;
        rd_data   = junk_record();
        if (pending) handshakes++;
        pending = 1'b0;
      end else if (rd_ovalid) begin
        rd_iready = 1'b1;
      end else if (pending) begin
        remaining--;
        if (remaining <= 0) begin
          rd_ovalid = 1'b1;
          rd_iready = ($urandom_range(99) < rd_stall_pct) ? 1'b0 : 1'b1;
          rd_data   = make_record(rec_seed, req_idx);
        end
      end
      if (!reset && stray_req && !rd_ovalid) begin
        rd_ovalid = 1'b1;
        rd_iready = 1'b1;
        rd_data   = junk_record();
      end
      if (!reset && !pending && !rd_ovalid && rd_read === 1'b1) begin
        pending   = 1'b1;
        req_idx   = rd_index;
        remaining = (rd_index == slow_idx) ? slow_delay : $urandom_range(rd_lat_max, 1);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [319:0] obs,
                             input logic [319:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] n);
    @(posedge clk);
    #1;
    ntris = n;
    start = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_busy"},      busy,      0);
    checkOutput({tag, "_done"},      done,      0);
    checkOutput({tag, "_rd_read"},   rd_read,   0);
    checkOutput({tag, "_rd_index"},  rd_index,  0);
    checkOutput({tag, "_tri_valid"}, tri_valid, 0);
    checkOutput({tag, "_tri_last"},  tri_last,  0);
    checkOutput({tag, "_tri_index"}, tri_index, 0);
    checkOutput({tag, "_tri_data"},  tri_data,  0);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, "_busy"},      busy,      0);
    checkOutput({tag, "_done"},      done,      0);
    checkOutput({tag, "_rd_read"},   rd_read,   0);
    checkOutput({tag, "_tri_valid"}, tri_valid, 0);
  endtask

  // Drains one sweep of n triangles, checking every popped entry against
  // the expected ordered stream and the done pulse that follows it.
  task automatic consume_stream(input int n, input int ready_pct,
                                input bit poke, input int budget);
    int                next_exp;
    bit                want_done;
    bit                finished;
    int                busy_bad;
    int                done_bad;
    bit                hold_prev;
    logic [31:0]       hold_idx;
    logic [ELEMSZ-1:0] hold_data;
    int                first_rd;
    int                first_tv;
    next_exp  = 0;
    want_done = 0;
    finished  = 0;
    busy_bad  = 0;
    done_bad  = 0;
    hold_prev = 0;
    hold_idx  = 32'd0;
    hold_data = '0;
    first_rd  = -1;
    first_tv  = -1;
    slow_held = 0;
    for (int c = 0; c < budget && !finished; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (want_done) begin
        checkOutput("done_pulse", done, 1);
        finished = 1;
      end else begin
        if (done !== 1'b0) done_bad++;
        if (busy !== 1'b1) busy_bad++;
        if (rd_read === 1'b1 && first_rd < 0) first_rd = c;
        if (tri_valid === 1'b1 && first_tv < 0) first_tv = c;
        if (rd_read === 1'b1 && rd_index === slow_idx) slow_held++;
        if (hold_prev) begin
          checkOutput("hold_valid", tri_valid, 1);
          checkOutput("hold_index", tri_index, hold_idx);
          checkOutput("hold_data",  tri_data,  hold_data);
        end
        tri_ready = ($urandom_range(99) < ready_pct);
        if (poke && $urandom_range(3) == 0) begin
          start = 1'b1;
          ntris = $urandom;
        end
        hold_prev = (tri_valid === 1'b1) && !tri_ready;
        hold_idx  = tri_index;
        hold_data = tri_data;
        if (tri_valid === 1'b1 && tri_ready) begin
          checkOutput("pop_index", tri_index, next_exp);
          checkOutput("pop_data",  tri_data,  make_record(rec_seed, next_exp));
          checkOutput("pop_last",  tri_last,  (next_exp == n - 1));
          if (next_exp == n - 1) want_done = 1;
          next_exp++;
        end
      end
    end
    start     = 1'b0;
    tri_ready = 1'b0;
    checkOutput("sweep_finished",    finished, 1);
    checkOutput("busy_during_sweep", busy_bad, 0);
    checkOutput("no_early_done",     done_bad, 0);
    last_latency = first_tv - first_rd;
  endtask

  initial begin : main
    int h0;
    int rd_late;
    int seen;
    int next_exp;
    reset     = 1'b1;
    start     = 1'b0;
    ntris     = 32'd0;
    tri_ready = 1'b0;

    // Reset state while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Three triangles, 1-cycle reader, consumer always ready.
    rec_seed   = $urandom;
    rd_lat_max = 1;
    applyStimulus(32'd3);
    consume_stream(3, 100, 0, 100);
    checkOutput("rd_to_valid_latency", last_latency, 2);
    idle_check("after_sweep3");

    // Zero triangles: immediate done, no reads, never busy.
    applyStimulus(32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("zero_done",    done,    1);
    checkOutput("zero_busy",    busy,    0);
    checkOutput("zero_rd_read", rd_read, 0);
    idle_check("zero_after");

    // Stalled consumer: FIFO fills after two captures and reads stop.
    rec_seed = $urandom;
    h0       = handshakes;
    rd_late  = 0;
    applyStimulus(32'd4);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      tri_ready = 1'b0;
      if (c >= 20 && rd_read !== 1'b0) rd_late++;
    end
    checkOutput("stalled_captures",    handshakes - h0, 2);
    checkOutput("stalled_rd_read_off", rd_late, 0);
    checkOutput("stalled_valid",       tri_valid, 1);
    consume_stream(4, 100, 0, 200);
    idle_check("after_stall");

    // Slow reader on index 1: request held until the late response.
    rec_seed   = $urandom;
    slow_idx   = 32'd1;
    slow_delay = 20;
    applyStimulus(32'd3);
    consume_stream(3, 100, 0, 300);
    checkOutput("slow_hold_cycles", slow_held, slow_delay + 1);
    slow_idx = 32'hFFFF_FFFF;
    idle_check("after_slow");

    // Randomised sweeps; odd runs also pulse start while busy.
    for (int k = 0; k < 5; k++) begin
      int n;
      n            = $urandom_range(8, 1);
      rec_seed     = $urandom;
      rd_lat_max   = $urandom_range(4, 1);
      rd_stall_pct = 30;
      applyStimulus(n);
      consume_stream(n, $urandom_range(90, 30), k[0], 600);
      idle_check("after_random");
    end
    rd_lat_max   = 1;
    rd_stall_pct = 0;

    // Maximum triangle count: early entries are never flagged last.
    rec_seed = $urandom;
    next_exp = 0;
    applyStimulus(32'hFFFF_FFFF);
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      tri_ready = 1'b1;
      if (tri_valid === 1'b1) begin
        checkOutput("max_index", tri_index, next_exp);
        checkOutput("max_last",  tri_last,  0);
        next_exp++;
      end
    end
    checkOutput("max_progress", next_exp >= 5, 1);
    tri_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset while waiting on index 2 of 5, then a stray response.
    rec_seed   = $urandom;
    slow_idx   = 32'd2;
    slow_delay = 100;
    seen       = 0;
    applyStimulus(32'd5);
    for (int c = 0; c < 60 && seen < 2; c++) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      tri_ready = 1'b1;
      if (rd_read === 1'b1 && rd_index === 32'd2) seen++;
    end
    checkOutput("reached_wait_idx2", seen, 2);
    tri_ready = 1'b0;
    reset     = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    check_all_zero("post_reset");
    reset     = 1'b0;
    stray_req = 1'b1;
    @(posedge clk);
    #1;
    stray_req = 1'b0;
    checkOutput("stray_not_captured", tri_valid, 0);
    checkOutput("stray_busy",         busy,      0);
    idle_check("stray_after");
    slow_idx = 32'hFFFF_FFFF;

    // A fresh single-triangle sweep works after the abandoned one.
    rec_seed = $urandom;
    applyStimulus(32'd1);
    consume_stream(1, 100, 0, 100);
    idle_check("after_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
